// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bus between a processor (master) and the data memory
// responder (slave).
//
// Signals:
//   req_valid   master -> slave  request present
//   req_ready   slave  -> master responder can take a request this cycle
//   req_we      master -> slave  1 = store, 0 = load
//   req_addr    master -> slave  32-bit byte address
//   req_wdata   master -> slave  store data
//   req_be      master -> slave  store byte enables
//   resp_valid  slave  -> master response present
//   resp_ready  master -> slave  master takes the response
//   resp_rdata  slave  -> master load data (0 for stores and errors)
//   resp_err    slave  -> master misaligned or out-of-range request
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding data memory with a fixed request-to-response latency.
// A request is accepted in IDLE; stores commit to memory on the accept edge,
// loads capture the word on the accept edge. After LATENCY edges (counting
// the accept edge) the response is presented and held until taken.
//
// Parameters:
//   DATA_W   data word width in bits
//   ADDR_W   word-address width, memory depth = 2**ADDR_W words
//   LATENCY  accept-to-response latency in edges, 1..7
//
// Ports:
//   clk      single clock, rising edge
//   reset    asynchronous, active-low reset (memory contents are kept)
//   bus      request/response bus, slave side
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam int         NBYTES    = DATA_W / 8;
    localparam logic [2:0] WAIT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [2:0]          count;
    logic [2:0]          next_count;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   next_rdata;
    logic                err_q;
    logic                next_err;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   word_idx;
    logic                addr_err;
    logic                accept;

    assign word_idx = bus.req_addr[ADDR_W+1:2];

    // Misaligned byte address or any address bit above the memory range.
    assign addr_err = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[31:ADDR_W+2]);

    // Gated by reset so the unreset memory cannot be written while reset is held.
    assign accept = reset && bus.req_valid && (state == IDLE);

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Next-state logic; response data and error are captured on the accept
    // edge and held untouched through WAIT and RESP.
    always_comb begin
        next_state = state;
        next_count = count;
        next_rdata = rdata_q;
        next_err   = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_err   = addr_err;
                    next_rdata = (addr_err || bus.req_we) ? '0 : mem[word_idx];
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        next_count = '0;
                    end else begin
                        next_state = WAIT;
                        next_count = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                // The edge that takes the counter to zero is the edge that enters RESP.
                if (count <= 3'd1) begin
                    next_state = RESP;
                    next_count = '0;
                end else begin
                    next_count = count - 3'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    next_state = IDLE;
                    next_rdata = '0;
                    next_err   = 1'b0;
                end
            end
            default: begin
                next_state = IDLE;
                next_count = '0;
            end
        endcase
    end

    // State and response registers; reset abandons any pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= next_state;
            count   <= next_count;
            rdata_q <= next_rdata;
            err_q   <= next_err;
        end
    end

    // Byte-masked store, committed on the accept edge. No reset: contents
    // survive a reset, including a store whose response was abandoned.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !addr_err) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.req_be[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder. Three instances (LATENCY 2, 1
// and 7) share the request stimulus; 'sel' picks which one is driven and
// observed. A byte-array memory model predicts load data and error flags.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic        resp_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    int          sel;

    logic        obs_req_ready;
    logic        obs_resp_valid;
    logic        obs_resp_err;
    logic [31:0] obs_resp_rdata;

    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] ref_mem [3][256];

    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_W(32)) bus_l2 ();
    data_mem_responder_if #(.DATA_W(32)) bus_l1 ();
    data_mem_responder_if #(.DATA_W(32)) bus_l7 ();

    data_mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset), .bus(bus_l2)
    );
    data_mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .bus(bus_l1)
    );
    data_mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(7)) dut_l7 (
        .clk(clk), .reset(reset), .bus(bus_l7)
    );

    assign bus_l2.req_valid  = req_valid && (sel == 0);
    assign bus_l2.req_we     = req_we;
    assign bus_l2.req_addr   = req_addr;
    assign bus_l2.req_wdata  = req_wdata;
    assign bus_l2.req_be     = req_be;
    assign bus_l2.resp_ready = resp_ready && (sel == 0);

    assign bus_l1.req_valid  = req_valid && (sel == 1);
    assign bus_l1.req_we     = req_we;
    assign bus_l1.req_addr   = req_addr;
    assign bus_l1.req_wdata  = req_wdata;
    assign bus_l1.req_be     = req_be;
    assign bus_l1.resp_ready = resp_ready && (sel == 1);

    assign bus_l7.req_valid  = req_valid && (sel == 2);
    assign bus_l7.req_we     = req_we;
    assign bus_l7.req_addr   = req_addr;
    assign bus_l7.req_wdata  = req_wdata;
    assign bus_l7.req_be     = req_be;
    assign bus_l7.resp_ready = resp_ready && (sel == 2);

    always_comb begin
        obs_req_ready  = bus_l2.req_ready;
        obs_resp_valid = bus_l2.resp_valid;
        obs_resp_err   = bus_l2.resp_err;
        obs_resp_rdata = bus_l2.resp_rdata;
        case (sel)
            1: begin
                obs_req_ready  = bus_l1.req_ready;
                obs_resp_valid = bus_l1.resp_valid;
                obs_resp_err   = bus_l1.resp_err;
                obs_resp_rdata = bus_l1.resp_rdata;
            end
            2: begin
                obs_req_ready  = bus_l7.req_ready;
                obs_resp_valid = bus_l7.resp_valid;
                obs_resp_err   = bus_l7.resp_err;
                obs_resp_rdata = bus_l7.resp_rdata;
            end
            default: ;
        endcase
    end

    function automatic int lat_for(input int s);
        case (s)
            1:       return 1;
            2:       return 7;
            default: return 2;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Junk store shown while the responder is busy; it must never be taken.
    task automatic drive_noise();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = {22'b0, 8'($urandom), 2'b00};
        req_wdata = $urandom;
        req_be    = 4'hF;
    endtask

    // One full transaction, entered and left at #1 after a rising edge.
    task automatic apply_stimulus(input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input int hold);
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          idx;
        int          n;
        exp_err   = (addr % 4 != 0) || (addr >= 32'd1024);
        idx       = int'(addr / 4) % 256;
        exp_rdata = '0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                exp_rdata = ref_mem[sel][idx];
            end
        end

        check_output("req_ready_idle", 32'(obs_req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk); #1;
        drive_noise();

        n = 1;
        while (obs_resp_valid !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("latency", 32'(n), 32'(lat_for(sel)));
        check_output("resp_rdata", obs_resp_rdata, exp_rdata);
        check_output("resp_err", 32'(obs_resp_err), 32'(exp_err));
        check_output("req_ready_busy", 32'(obs_req_ready), 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            drive_noise();
            check_output("hold_valid", 32'(obs_resp_valid), 32'd1);
            check_output("hold_rdata", obs_resp_rdata, exp_rdata);
            check_output("hold_req_ready", 32'(obs_req_ready), 32'd0);
        end

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_output("done_valid", 32'(obs_resp_valid), 32'd0);
        check_output("done_req_ready", 32'(obs_req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit saw_valid;
        bit rwe;
        logic [31:0] raddr;

        reset      = 1'b0;
        sel        = 0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b0;

        // Reset values
        #1;
        check_output("rst_resp_valid", 32'(obs_resp_valid), 32'd0);
        check_output("rst_resp_rdata", obs_resp_rdata, 32'd0);
        check_output("rst_resp_err", 32'(obs_resp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_output("rst_req_ready", 32'(obs_req_ready), 32'd1);

        $display("[TB] filling LATENCY=2 memory");
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
        end

        $display("[TB] directed store/load sequence");
        apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
        apply_stimulus(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check_output("model_merge", ref_mem[0][4], 32'hDEADBEAA);

        apply_stimulus(1'b0, 32'h12, 32'h0, 4'h0, 0);
        apply_stimulus(1'b0, 32'h400, 32'h0, 4'h0, 0);
        apply_stimulus(1'b1, 32'h12, 32'h55555555, 4'hF, 0);
        apply_stimulus(1'b1, 32'h400, 32'h66666666, 4'hF, 0);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 0);
        apply_stimulus(1'b1, 32'h20, 32'h77777777, 4'h0, 0);
        apply_stimulus(1'b0, 32'h20, 32'h0, 4'h0, 0);

        $display("[TB] backpressure hold");
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 5);
        apply_stimulus(1'b0, 32'h14, 32'h0, 4'h0, 0);

        $display("[TB] reset during WAIT of a store");
        apply_stimulus(1'b1, 32'h0, 32'h0, 4'h0, 0);
        ref_mem[0][5] = 32'h12345678;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h14;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("store_wait_busy", 32'(obs_req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_output("store_rst_valid", 32'(obs_resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("store_rel_ready", 32'(obs_req_ready), 32'd1);
        @(posedge clk); #1;

        $display("[TB] reset during WAIT of a load");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("load_wait_busy", 32'(obs_req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_output("load_rst_valid", 32'(obs_resp_valid), 32'd0);
        check_output("load_rst_rdata", obs_resp_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("load_rel_ready", 32'(obs_req_ready), 32'd1);
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (obs_resp_valid === 1'b1) saw_valid = 1'b1;
        end
        check_output("no_stale_resp", 32'(saw_valid), 32'd0);
        apply_stimulus(1'b0, 32'h14, 32'h0, 4'h0, 0);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 150; t++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            rwe  = 1'($urandom);
            if (kind == 0)      raddr = {22'b0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (kind == 1) raddr = $urandom | 32'h400;
            else                raddr = {22'b0, 8'($urandom), 2'b00};
            apply_stimulus(rwe, raddr, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] LATENCY=1 and LATENCY=7 instances");
        sel = 1;
        apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 2);
        sel = 2;
        apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 2);
        apply_stimulus(1'b0, 32'h402, 32'h0, 4'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
